// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing the async FIFO read port among NUM_REQ consumers.
// A grant lasts for at most BURST_LEN pops, and each pop is driven by the granted consumer's rd_ready.
module fifo_rd_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4
) (
   input  logic                  r_clk,
   input  logic                  r_rst,
   input  logic                  rempty,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  rinc,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    rd_ready,
   output logic [NUM_REQ-1:0]    rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [NUM_REQ-1:0]    grant,
   output logic                  busy
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(BURST_LEN) + 1;
   localparam logic [NUM_REQ-1:0] GRANT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]      LAST_BEAT = CW'(BURST_LEN - 1);
   localparam logic [IW-1:0]      LAST_IDX  = IW'(NUM_REQ - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t               state_r;
   logic [NUM_REQ-1:0]   grant_r;
   logic [IW-1:0]        gidx_r;
   logic [IW-1:0]        rr_ptr_r;
   logic [CW-1:0]        beat_cnt_r;

   logic                 win_found_s;
   logic [IW-1:0]        win_idx_s;
   logic                 pop_s;
   logic                 exit_s;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
      if (idx == LAST_IDX) begin
         next_idx = '0;
      end else begin
         next_idx = idx + IW'(1);
      end
   endfunction

   // Round-robin search for the first requester starting at rr_ptr_r
   always_comb begin
      int idx;
      win_found_s = 1'b0;
      win_idx_s   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_r) + k) % NUM_REQ;
         if (!win_found_s && req[idx]) begin
            win_found_s = 1'b1;
            win_idx_s   = IW'(idx);
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Pop handshake and burst termination for the granted consumer
   always_comb begin
      pop_s  = 1'b0;
      exit_s = 1'b0;
      if (state_r == ST_BURST) begin
         pop_s  = !rempty && rd_ready[gidx_r];
         exit_s = (pop_s && (beat_cnt_r == LAST_BEAT)) || (!req[gidx_r] && !pop_s);
      end else begin
         pop_s  = 1'b0;
         exit_s = 1'b0;
      end
   end

   // Pop and valid follow state directly so that reset drops them without a clock edge
   assign rinc     = pop_s;
   assign rd_valid = ((state_r == ST_BURST) && !rempty) ? grant_r : '0;
   assign rd_data  = rdata;
   assign grant    = grant_r;
   assign busy     = (state_r == ST_BURST);

   // Arbitration FSM, grant and beat counter
   always_ff @(posedge r_clk or negedge r_rst) begin
      if (!r_rst) begin
         state_r    <= ST_IDLE;
         grant_r    <= '0;
         gidx_r     <= '0;
         rr_ptr_r   <= '0;
         beat_cnt_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (win_found_s && !rempty) begin
                  state_r    <= ST_BURST;
                  grant_r    <= GRANT_LSB << win_idx_s;
                  gidx_r     <= win_idx_s;
                  beat_cnt_r <= '0;
               end else begin
                  state_r    <= ST_IDLE;
                  grant_r    <= '0;
               end
            end
            ST_BURST: begin
               if (exit_s) begin
                  state_r    <= ST_IDLE;
                  grant_r    <= '0;
                  rr_ptr_r   <= next_idx(gidx_r);
                  beat_cnt_r <= '0;
               end else if (pop_s) begin
                  beat_cnt_r <= beat_cnt_r + CW'(1);
               end else begin
                  beat_cnt_r <= beat_cnt_r;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               grant_r    <= '0;
               beat_cnt_r <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter: a FIFO model feeds the DUT, expected pops are queued
// by the stimulus and checked by a monitor on every rinc pulse.
module tb_fifo_rd_arbiter;
   localparam int NR = 4;
   localparam int DW = 8;

   logic          r_clk;
   logic          r_rst;
   logic          rempty;
   logic [DW-1:0] rdata;
   logic          rinc;
   logic [NR-1:0] req;
   logic [NR-1:0] rd_ready;
   logic [NR-1:0] rd_valid;
   logic [DW-1:0] rd_data;
   logic [NR-1:0] grant;
   logic          busy;

   typedef struct packed {
      logic [NR-1:0] g;
      logic [DW-1:0] d;
   } exp_t;

   exp_t    exp_q[$];
   int      tests;
   int      fails;
   int      n_grants;
   int      wr_ptr;
   int      rd_ptr;
   int      exp_idx;
   logic    prev_busy;
   logic [DW-1:0] mem [256];

   fifo_rd_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(4)) dut (
      .r_clk(r_clk), .r_rst(r_rst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
      .req(req), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
      .grant(grant), .busy(busy)
   );

   initial r_clk = 1'b0;
   always #5 r_clk = ~r_clk;

   function automatic logic [DW-1:0] word_of(input int i);
      return DW'((i * 37 + 11) % 256);
   endfunction

   assign rempty = (wr_ptr == rd_ptr);
   assign rdata  = mem[rd_ptr % 256];

   always @(posedge r_clk) begin
      if (rinc) rd_ptr <= rd_ptr + 1;
   end

   // Monitor: every pop must match the next queued expectation; invariants checked each cycle
   always @(negedge r_clk) begin
      exp_t e;
      if (busy && !prev_busy) n_grants = n_grants + 1;
      prev_busy = busy;
      tests = tests + 1;
      if ((rinc && (rempty || !busy)) || ((grant & (grant - 4'd1)) != 4'd0) ||
          (rd_valid != ((busy && !rempty) ? grant : 4'd0))) begin
         fails = fails + 1;
         $display("FAIL invariant: rinc=%b rempty=%b busy=%b grant=%b rd_valid=%b", rinc, rempty, busy, grant, rd_valid);
      end
      if (rinc) begin
         tests = tests + 1;
         if (exp_q.size() == 0) begin
            fails = fails + 1;
            $display("FAIL unexpected_pop: grant=%b data=%h, required no pop", grant, rd_data);
         end else begin
            e = exp_q.pop_front();
            if (grant != e.g || rd_data != e.d) begin
               fails = fails + 1;
               $display("FAIL pop: grant=%b data=%h, required grant=%b data=%h", grant, rd_data, e.g, e.d);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      tests = tests + 1;
      if (act !== req_v) begin
         fails = fails + 1;
         $display("FAIL %s: got %0h, required %0h", name, act, req_v);
      end
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr % 256] = word_of(wr_ptr);
         wr_ptr = wr_ptr + 1;
      end
   endtask

   task automatic expect_pops(input logic [NR-1:0] g, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.g = g;
         e.d = word_of(exp_idx);
         exp_q.push_back(e);
         exp_idx = exp_idx + 1;
      end
   endtask

   task automatic wait_q(input int left, input string name);
      int c;
      c = 0;
      while (exp_q.size() > left && c < 200) begin
         @(posedge r_clk); #1;
         c = c + 1;
      end
      if (exp_q.size() > left) chk({name, "_timeout"}, 32'(exp_q.size()), 32'(left));
   endtask

   task automatic wait_busy(input logic val, input string name);
      int c;
      c = 0;
      while (busy != val && c < 200) begin
         @(posedge r_clk); #1;
         c = c + 1;
      end
      if (busy != val) chk({name, "_timeout"}, 32'(busy), 32'(val));
   endtask

   task automatic do_reset();
      r_rst = 1'b0;
      repeat (2) @(posedge r_clk);
      #1 r_rst = 1'b1;
      n_grants = 0;
   endtask

   initial begin
      tests = 0; fails = 0; n_grants = 0; wr_ptr = 0; rd_ptr = 0; exp_idx = 0;
      prev_busy = 1'b0;
      req = 4'b0000; rd_ready = 4'b0000; r_rst = 1'b1;
      #2 r_rst = 1'b0;
      #1;
      chk("reset_grant", 32'(grant), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_rinc", 32'(rinc), 32'h0);
      chk("reset_rd_valid", 32'(rd_valid), 32'h0);
      do_reset();

      // T1: single requester, 10 words -> bursts of 4,4,2
      req = 4'b0001; rd_ready = 4'b1111;
      expect_pops(4'b0001, 10);
      push_words(10);
      wait_q(0, "t1_drain");
      @(posedge r_clk); #1;
      chk("t1_stall_busy", 32'(busy), 32'h1);
      chk("t1_stall_grant", 32'(grant), 32'h1);
      req = 4'b0000;
      wait_busy(1'b0, "t1_idle");
      chk("t1_bursts", 32'(n_grants), 32'd3);
      chk("t1_rempty", 32'(rempty), 32'h1);

      // T2: all requesting, FIFO stocked -> rotating grants of 4 pops each
      do_reset();
      req = 4'b1111;
      expect_pops(4'b0001, 4);
      expect_pops(4'b0010, 4);
      expect_pops(4'b0100, 4);
      expect_pops(4'b1000, 4);
      expect_pops(4'b0001, 4);
      push_words(20);
      wait_q(0, "t2_drain");
      wait_busy(1'b0, "t2_idle");
      req = 4'b0000;
      chk("t2_bursts", 32'(n_grants), 32'd5);

      // T3: rd_ready toggling -> pops only on ready cycles, burst ends after 4th pop
      do_reset();
      req = 4'b0001; rd_ready = 4'b0000;
      expect_pops(4'b0001, 4);
      push_words(4);
      wait_busy(1'b1, "t3_grant");
      for (int i = 0; i < 8; i++) begin
         rd_ready = (i % 2 == 0) ? 4'b0001 : 4'b0000;
         @(negedge r_clk);
         chk($sformatf("t3_rinc_%0d", i), 32'(rinc), (i % 2 == 0 && i < 7) ? 32'h1 : 32'h0);
         @(posedge r_clk); #1;
      end
      chk("t3_done_busy", 32'(busy), 32'h0);
      chk("t3_bursts", 32'(n_grants), 32'd1);
      req = 4'b0000; rd_ready = 4'b1111;

      // T4: FIFO empties after 2 pops, refilled 5 cycles later
      do_reset();
      req = 4'b0001;
      expect_pops(4'b0001, 4);
      push_words(2);
      wait_q(2, "t4_first");
      for (int i = 0; i < 5; i++) begin
         @(negedge r_clk);
         chk($sformatf("t4_stall_rinc_%0d", i), 32'(rinc), 32'h0);
         chk($sformatf("t4_stall_grant_%0d", i), 32'(grant), 32'h1);
      end
      @(posedge r_clk); #1;
      push_words(2);
      wait_q(0, "t4_drain");
      wait_busy(1'b0, "t4_idle");
      req = 4'b0000;
      chk("t4_bursts", 32'(n_grants), 32'd1);

      // T5: granted requester drops after one pop -> next grant moves on
      do_reset();
      req = 4'b0011; rd_ready = 4'b0000;
      expect_pops(4'b0001, 1);
      expect_pops(4'b0010, 4);
      push_words(5);
      wait_busy(1'b1, "t5_grant");
      chk("t5_first_grant", 32'(grant), 32'h1);
      rd_ready = 4'b0001;
      @(posedge r_clk); #1;
      rd_ready = 4'b0000; req = 4'b0010;
      @(posedge r_clk); #1;
      chk("t5_exit_busy", 32'(busy), 32'h0);
      chk("t5_exit_grant", 32'(grant), 32'h0);
      req = 4'b0011;
      @(posedge r_clk); #1;
      chk("t5_next_grant", 32'(grant), 32'h2);
      rd_ready = 4'b1111;
      wait_q(0, "t5_drain");
      wait_busy(1'b0, "t5_idle");
      req = 4'b0000;

      // T6: reset mid-burst with beat_cnt=2, then fresh arbitration from index 0
      do_reset();
      req = 4'b0110; rd_ready = 4'b1111;
      expect_pops(4'b0010, 2);
      push_words(6);
      wait_q(0, "t6_first");
      r_rst = 1'b0;
      #1;
      chk("t6_rst_rinc", 32'(rinc), 32'h0);
      chk("t6_rst_rd_valid", 32'(rd_valid), 32'h0);
      chk("t6_rst_grant", 32'(grant), 32'h0);
      chk("t6_rst_busy", 32'(busy), 32'h0);
      expect_pops(4'b0010, 4);
      @(posedge r_clk); #1;
      r_rst = 1'b1;
      @(posedge r_clk); #1;
      chk("t6_regrant", 32'(grant), 32'h2);
      wait_q(0, "t6_drain");
      wait_busy(1'b0, "t6_idle");
      req = 4'b0000;
      repeat (3) @(posedge r_clk);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
